// File: rtl/program_counter_if.sv
// ============================================================================
// program_counter_if : next-pc select/target bundle and pc readback. Rev 1.0
// ============================================================================
`default_nettype none

interface program_counter_if;
  logic [1:0]  pcControl;
  logic [25:0] jumpAddress;
  logic [15:0] branchOffset;
  logic [31:0] regAddress;
  logic [31:0] pc;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalignedFault;

  modport master (
    output pcControl, jumpAddress, branchOffset, regAddress,
    input  pc, misalignedFault
  );
  modport slave (
    input  pcControl, jumpAddress, branchOffset, regAddress,
    output pc, misalignedFault
  );
`else
  modport master (
    output pcControl, jumpAddress, branchOffset, regAddress,
    input  pc
  );
  modport slave (
    input  pcControl, jumpAddress, branchOffset, regAddress,
    output pc
  );
`endif
endinterface

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// program_counter : MIPS-style fetch address register (seq/jump/branch/jr).
// Optional macro PC_MISALIGN_TRAP_EN aligns jr targets and flags them. Rev 1.0
// ============================================================================
`default_nettype none

module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  wire logic         clk,
  input  wire logic         reset,
  program_counter_if.slave  bus
);

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_REG    = 2'b11;

  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        fault_next;

  always_comb begin
    pc_plus4   = pc_reg + 32'd4;
    pc_next    = pc_plus4;
    fault_next = 1'b0;
    case (bus.pcControl)
      SEL_SEQ:    pc_next = pc_plus4;
      // Region bits come from pc+4 so a jump in the last slot of a 256MB
      // region lands in the following one.
      SEL_JUMP:   pc_next = {pc_plus4[31:28], bus.jumpAddress, 2'b00};
      SEL_BRANCH: pc_next = pc_plus4 +
                            {{14{bus.branchOffset[15]}}, bus.branchOffset, 2'b00};
      SEL_REG: begin
`ifdef PC_MISALIGN_TRAP_EN
        pc_next    = {bus.regAddress[31:2], 2'b00};
        fault_next = |bus.regAddress[1:0];
`else
        pc_next    = bus.regAddress;
`endif
      end
      default:    pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign bus.pc = pc_reg;

`ifdef PC_MISALIGN_TRAP_EN
  logic fault_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= fault_next;
    end
  end

  assign bus.misalignedFault = fault_reg;
`else
  logic unused_fault;
  assign unused_fault = fault_next;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// Bench for program_counter: address-arithmetic reference model checked every
// cycle, plus directed vectors with literal expected pc values.
`default_nettype none

module tb_program_counter;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  program_counter_if bus();

  program_counter #(.RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: next address computed with plain integer arithmetic.
  logic [31:0] exp_pc;
  logic        exp_fault;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] nxt;
    nxt = exp_pc + 32'd4;
    if (reset) begin
      exp_pc      = RV;
      exp_fault   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_fault = 1'b0;
      case (bus.pcControl)
        2'd0: exp_pc = nxt;
        2'd1: exp_pc = (nxt & 32'hF000_0000) | (32'(bus.jumpAddress) * 32'd4);
        2'd2: exp_pc = nxt + 32'(int'($signed(bus.branchOffset)) * 4);
        default: begin
`ifdef PC_MISALIGN_TRAP_EN
          exp_pc    = bus.regAddress - (bus.regAddress % 32'd4);
          exp_fault = (bus.regAddress % 32'd4) != 0;
`else
          exp_pc    = bus.regAddress;
`endif
        end
      endcase
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check32("model_pc", bus.pc, exp_pc);
`ifdef PC_MISALIGN_TRAP_EN
      check32("model_fault", 32'(bus.misalignedFault), 32'(exp_fault));
`endif
    end
  end

  task automatic step(input logic r, input logic [1:0] c, input logic [25:0] j,
                      input logic [15:0] b, input logic [31:0] a);
    reset            = r;
    bus.pcControl    = c;
    bus.jumpAddress  = j;
    bus.branchOffset = b;
    bus.regAddress   = a;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b0, 2'b11, 26'h0, 16'h0, a);
  endtask

  task automatic check_fault(input string name, input logic req);
`ifdef PC_MISALIGN_TRAP_EN
    check32(name, 32'(bus.misalignedFault), 32'(req));
`else
    if (req) check32(name, 32'd0, 32'd1);
`endif
  endtask

  initial begin
    step(1'b1, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("reset_1", bus.pc, 32'h0);
    check_fault("reset_fault", 1'b0);
    step(1'b1, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("reset_2", bus.pc, 32'h0);
    step(1'b0, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("seq_4", bus.pc, 32'h4);
    step(1'b0, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("seq_8", bus.pc, 32'h8);
    step(1'b0, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("seq_12", bus.pc, 32'hC);

    load(32'h0000_0010);
    check32("reg_10", bus.pc, 32'h10);
    step(1'b0, 2'b10, 26'h3FF_FFFF, 16'hFFFC, 32'hDEAD_BEEF);
    check32("branch_neg", bus.pc, 32'h4);

    load(32'h0000_0010);
    step(1'b0, 2'b10, 26'h0, 16'h0003, 32'h0);
    check32("branch_pos", bus.pc, 32'h20);

    load(32'h0000_0000);
    step(1'b0, 2'b10, 26'h0, 16'h8000, 32'h0);
    check32("branch_wrap", bus.pc, 32'hFFFE_0004);

    load(32'h4000_0000);
    step(1'b0, 2'b01, 26'h000_0100, 16'hFFFF, 32'h0);
    check32("jump", bus.pc, 32'h4000_0400);

    load(32'h0FFF_FFFC);
    step(1'b0, 2'b01, 26'h000_0100, 16'h0, 32'h0);
    check32("jump_region", bus.pc, 32'h1000_0400);

    load(32'hFFFF_FFFC);
    step(1'b0, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("seq_wrap", bus.pc, 32'h0);

    load(32'h0000_1234);
    check32("reg_aligned", bus.pc, 32'h1234);
    check_fault("reg_aligned_fault", 1'b0);

    load(32'h0000_1237);
`ifdef PC_MISALIGN_TRAP_EN
    check32("reg_misaligned", bus.pc, 32'h1234);
    check_fault("fault_pulse", 1'b1);
    step(1'b0, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("after_trap_seq", bus.pc, 32'h1238);
    check_fault("fault_clear", 1'b0);
`else
    check32("reg_misaligned", bus.pc, 32'h1237);
    step(1'b0, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("after_reg_seq", bus.pc, 32'h123B);
`endif

    load(32'h0000_1237);
    step(1'b1, 2'b01, 26'h3FF_FFFF, 16'h0, 32'h0);
    check32("reset_priority", bus.pc, RV);
    check_fault("reset_priority_fault", 1'b0);
    step(1'b0, 2'b00, 26'h0, 16'h0, 32'h0);
    check32("resume", bus.pc, RV + 32'd4);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
